// File: rtl/dht11_bcd_formatter_pkg.sv
// Shared constants for the DHT11 BCD formatter.
// FSM encodings, field widths and the add-3 helper.
package dht11_bcd_formatter_pkg;

  localparam int DHT_W      = 8;
  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Adds 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] add3(
    input logic [BCD_W-1:0] b
  );
    logic [BCD_W-1:0] r;
    r = b;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (r[d*4 +: 4] >= 4'd5)
        r[d*4 +: 4] = r[d*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/dht11_bcd_formatter_bin2bcd.sv
// Per-byte shift-add-3 datapath; one bit per step.
// result is the BCD value after the step taken this cycle.
module dht_bin2bcd8
  import dht11_bcd_formatter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [DHT_W-1:0] din,
  output logic [BCD_W-1:0] result
);

  logic [DHT_W-1:0] bin;
  logic [BCD_W-1:0] bcd;

  // Next BCD value: correct the digits, then shift in the next MSB.
  always_comb begin
    result = {add3(bcd), bin[DHT_W-1]};
    result = result;
  end

  // Shift registers: load clears BCD, step advances one bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin <= '0;
      bcd <= '0;
    end else if (load) begin
      bin <= din;
      bcd <= '0;
    end else if (step) begin
      bin <= {bin[DHT_W-2:0], 1'b0};
      bcd <= result;
    end
  end

endmodule

// File: rtl/dht11_bcd_formatter.sv
// Captures DHT11 readings, converts to 3-digit BCD, flags stale data.
// Optional temperature min/max tracking under DHT_TEMP_MINMAX_EN.
module dht11_bcd_formatter
  import dht11_bcd_formatter_pkg::*;
#(
  parameter int unsigned STALE_US = 3_000_000,
  parameter int          CNT_W    = 32
) (
  input  logic             iClk,
  input  logic             iRstn,
  input  logic             iTickUs,
  input  logic [DHT_W-1:0] iHumInt,
  input  logic [DHT_W-1:0] iTempInt,
  input  logic             iDataValid,
  output logic [BCD_W-1:0] oHumBcd,
  output logic [BCD_W-1:0] oTempBcd,
  output logic             oBcdValid,
  output logic             oBusy,
  output logic             oStale,
  output logic [DHT_W-1:0] oTempMin,
  output logic [DHT_W-1:0] oTempMax
);

  localparam logic [CNT_W-1:0] STALE_MAX = CNT_W'(STALE_US);

  logic [1:0]       state;
  logic [2:0]       cnt;
  logic             prev_valid;
  logic             pending;
  logic [DHT_W-1:0] last_hum;
  logic [DHT_W-1:0] last_temp;
  logic [CNT_W-1:0] stale_cnt;
  logic             trigger;
  logic             start;
  logic             step;
  logic [BCD_W-1:0] hum_res;
  logic [BCD_W-1:0] temp_res;

  // New reading: valid rose, or the bytes differ from the last capture.
  always_comb begin
    trigger = iDataValid
            && (!prev_valid
                || iHumInt != last_hum
                || iTempInt != last_temp);
    start   = (state == ST_IDLE) && (trigger || pending);
    step    = (state == ST_CONV);
  end

  assign oBusy = (state != ST_IDLE);

  dht_bin2bcd8 u_hum (
    .clk    (iClk),
    .rst_n  (iRstn),
    .load   (start),
    .step   (step),
    .din    (iHumInt),
    .result (hum_res)
  );

  dht_bin2bcd8 u_temp (
    .clk    (iClk),
    .rst_n  (iRstn),
    .load   (start),
    .step   (step),
    .din    (iTempInt),
    .result (temp_res)
  );

  // Conversion sequencer, capture registers and output publish.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      prev_valid <= 1'b0;
      pending    <= 1'b0;
      last_hum   <= '0;
      last_temp  <= '0;
      oHumBcd    <= '0;
      oTempBcd   <= '0;
      oBcdValid  <= 1'b0;
    end else begin
      prev_valid <= iDataValid;
      oBcdValid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            last_hum  <= iHumInt;
            last_temp <= iTempInt;
            pending   <= 1'b0;
            cnt       <= '0;
            state     <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (trigger) pending <= 1'b1;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state     <= ST_DONE;
            oHumBcd   <= hum_res;
            oTempBcd  <= temp_res;
            oBcdValid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (trigger) pending <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Counts microseconds of invalid data, saturating at the limit.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      stale_cnt <= '0;
      oStale    <= 1'b0;
    end else begin
      if (iDataValid)
        stale_cnt <= '0;
      else if (iTickUs && stale_cnt != STALE_MAX)
        stale_cnt <= stale_cnt + 1'b1;
      oStale <= (stale_cnt == STALE_MAX) && !iDataValid;
    end
  end

`ifdef DHT_TEMP_MINMAX_EN
  logic [DHT_W-1:0] t_min;
  logic [DHT_W-1:0] t_max;
  logic             seen;

  // Tracks temperature extremes over all captures.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      t_min <= '1;
      t_max <= '0;
      seen  <= 1'b0;
    end else if (start) begin
      if (iTempInt < t_min) t_min <= iTempInt;
      if (iTempInt > t_max) t_max <= iTempInt;
      seen <= 1'b1;
    end
  end

  assign oTempMin = seen ? t_min : '0;
  assign oTempMax = seen ? t_max : '0;
`else
  assign oTempMin = '0;
  assign oTempMax = '0;
`endif

endmodule
